// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready request and response handshakes.
// Single-cycle arithmetic/logic/shift ops, iterative shift-add multiply and
// an optional restoring divider compiled in with the ALU_MC_DIV_EN macro.
// Without ALU_MC_DIV_EN, ops 9/10 are treated as illegal and no divider exists.
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       cc,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef ALU_MC_DIV_EN
    DIV  = 2'd3,
`endif
    HOLD = 2'd2
  } state_t;

  state_t state, state_next, target;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, mcand, mplier, mul_acc_next;
  logic [WIDTH-1:0] sc_result;
  logic [3:0]       sc_cc;
  logic [WIDTH:0]   sum;
  logic             sc_c, sc_v, sc_illegal;
  logic             accept, last;

`ifdef ALU_MC_DIV_EN
  logic [3:0]       op_q;
  logic [WIDTH-1:0] rem, quo, dvsr, rem_next, quo_next, div_res;
  logic [WIDTH:0]   div_shift, div_diff;
`endif

  assign in_ready  = (state == IDLE) || (state == HOLD && out_ready);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CNT_LAST);

  // Destination state for an accepted request, decoded from the op code.
  always_comb begin
    target = HOLD;
    if (op == 4'd8) target = MUL;
`ifdef ALU_MC_DIV_EN
    if (op == 4'd9 || op == 4'd10) target = DIV;
`endif
  end

  // Single-cycle ops and their flags; anything unhandled here is illegal.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    sum        = '0;
    sc_result  = '0;
    sc_c       = 1'b0;
    sc_v       = 1'b0;
    sc_illegal = 1'b0;
    case (op)
      4'd0: begin
        sum       = {1'b0, a} + {1'b0, b};
        sc_result = sum[WIDTH-1:0];
        sc_c      = sum[WIDTH];
        sc_v      = (a[WIDTH-1] == b[WIDTH-1]) && (sc_result[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        sum       = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        sc_result = sum[WIDTH-1:0];
        sc_c      = sum[WIDTH];
        sc_v      = (a[WIDTH-1] != b[WIDTH-1]) && (sc_result[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: sc_result = a & b;
      4'd3: sc_result = a | b;
      4'd4: sc_result = a ^ b;
      4'd5: sc_result = (b >= SHIFT_LIM) ? '0 : (a << b);
      4'd6: sc_result = (b >= SHIFT_LIM) ? '0 : (a >> b);
      4'd7: sc_result = (b >= SHIFT_LIM) ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> b);
      default: sc_illegal = 1'b1;
    endcase
    sc_cc = sc_illegal ? 4'b0101
                       : {sc_result[WIDTH-1], ~|sc_result, sc_c, sc_v};
  end

  // One shift-add multiply step: add the shifted multiplicand when the low multiplier bit is set.
  assign mul_acc_next = mplier[0] ? (acc + mcand) : acc;

`ifdef ALU_MC_DIV_EN
  // One restoring divide step. A zero divisor always "subtracts", which
  // naturally yields an all-ones quotient and leaves the dividend as remainder.
  always_comb begin
    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, dvsr};
    if (!div_diff[WIDTH]) begin
      rem_next = div_diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = div_shift[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
    div_res = (op_q == 4'd10) ? rem_next : quo_next;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = target;
      MUL:     if (last) state_next = HOLD;
`ifdef ALU_MC_DIV_EN
      DIV:     if (last) state_next = HOLD;
`endif
      HOLD:    if (out_ready) state_next = in_valid ? target : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on acceptance, iterate in MUL/DIV, hold the result in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      result <= '0;
      cc     <= 4'b0000;
`ifdef ALU_MC_DIV_EN
      op_q   <= 4'd0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
`endif
    end else begin
      case (state)
        MUL: begin
          acc    <= mul_acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= last ? '0 : cnt + 1'b1;
          if (last) begin
            result <= mul_acc_next;
            cc     <= {mul_acc_next[WIDTH-1], ~|mul_acc_next, 2'b00};
          end
        end
`ifdef ALU_MC_DIV_EN
        DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            result <= div_res;
            cc     <= {div_res[WIDTH-1], ~|div_res, 1'b0, ~|dvsr};
          end
        end
`endif
        default: begin
          if (accept) begin
            cnt <= '0;
            if (target == MUL) begin
              acc    <= '0;
              mcand  <= a;
              mplier <= b;
`ifdef ALU_MC_DIV_EN
            end else if (target == DIV) begin
              op_q <= op;
              rem  <= '0;
              quo  <= a;
              dvsr <= b;
`endif
            end else begin
              result <= sc_result;
              cc     <= sc_cc;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=16.
// Expectations for ops 9/10 follow whether ALU_MC_DIV_EN is defined.
module tb_alu_mc;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       cc;
  logic             out_valid;
  logic             out_ready;

  int errors = 0;
  int checks = 0;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .cc        (cc),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the response and check it.
  task automatic do_op(input string tag, input logic [3:0] o, input logic [15:0] x,
                       input logic [15:0] y, input logic [15:0] er, input logic [3:0] ec,
                       input int el, input bit chk_busy);
    int  guard;
    int  lat;
    bit  ready_seen;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, " in_ready"}, in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
    lat = 1;
    ready_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, el);
    check({tag, " result"}, result, er);
    check({tag, " cc"}, cc, ec);
    if (chk_busy) check({tag, " busy in_ready"}, ready_seen, 0);
  endtask

  initial begin
    logic [15:0] held_res;
    logic [3:0]  held_cc;
    bit          stale;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 4'd0; a = '0; b = '0;
    #12;
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset result", result, 16'h0000);
    check("reset cc", cc, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Arithmetic and flag corners.
    do_op("add ovf",     4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1, 0);
    do_op("sub zero",    4'd1, 16'h0005, 16'h0005, 16'h0000, 4'b0110, 1, 0);
    do_op("asr 20",      4'd7, 16'h8000, 16'd20,   16'hFFFF, 4'b1000, 1, 0);
    do_op("add carry",   4'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1, 0);
    do_op("sub borrow",  4'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b1000, 1, 0);
    do_op("sub ovf",     4'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1, 0);
    // Logic and shifts, including the b>=WIDTH boundary.
    do_op("and",         4'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1, 0);
    do_op("or",          4'd3, 16'hF0F0, 16'h0FF0, 16'hFFF0, 4'b1000, 1, 0);
    do_op("xor",         4'd4, 16'hF0F0, 16'h0FF0, 16'hFF00, 4'b1000, 1, 0);
    do_op("shl 15",      4'd5, 16'h0001, 16'd15,   16'h8000, 4'b1000, 1, 0);
    do_op("shl 16",      4'd5, 16'h0001, 16'd16,   16'h0000, 4'b0100, 1, 0);
    do_op("shr 15",      4'd6, 16'h8000, 16'd15,   16'h0001, 4'b0000, 1, 0);
    do_op("shr big",     4'd6, 16'hFFFF, 16'h8000, 16'h0000, 4'b0100, 1, 0);
    do_op("asr 15",      4'd7, 16'h8000, 16'd15,   16'hFFFF, 4'b1000, 1, 0);
    do_op("asr pos big", 4'd7, 16'h7FFF, 16'd40,   16'h0000, 4'b0100, 1, 0);
    // Multiply.
    do_op("mul wrap",    4'd8, 16'h0100, 16'h0100, 16'h0000, 4'b0100, 17, 1);
    do_op("mul 3x5",     4'd8, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 17, 1);
    do_op("mul ffff^2",  4'd8, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0000, 17, 1);
    // Divide.
`ifdef ALU_MC_DIV_EN
    do_op("divu 100/7",  4'd9,  16'd100, 16'd7, 16'h000E, 4'b0000, 17, 1);
    do_op("remu 100/7",  4'd10, 16'd100, 16'd7, 16'h0002, 4'b0000, 17, 1);
    do_op("divu 5/0",    4'd9,  16'd5,   16'd0, 16'hFFFF, 4'b1001, 17, 1);
    do_op("remu 5/0",    4'd10, 16'd5,   16'd0, 16'h0005, 4'b0001, 17, 1);
`else
    do_op("divu off",    4'd9,  16'd100, 16'd7, 16'h0000, 4'b0101, 1, 0);
    do_op("remu off",    4'd10, 16'd100, 16'd7, 16'h0000, 4'b0101, 1, 0);
`endif
    do_op("illegal 15",  4'd15, 16'h1234, 16'h5678, 16'h0000, 4'b0101, 1, 0);

    // Backpressure: result held while out_ready is low, then back-to-back accept.
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op("xor hold",    4'd4, 16'h00F0, 16'h0FFF, 16'h0F0F, 4'b0000, 1, 0);
    held_res = result;
    held_cc  = cc;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold out_valid", out_valid, 1);
      check("hold in_ready", in_ready, 0);
      check("hold result", result, 16'h0F0F);
      check("hold cc", cc, held_cc);
    end
    op = 4'd3; a = 16'h00F0; b = 16'h000F; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("b2b in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b out_valid", out_valid, 1);
    check("b2b result", result, 16'h00FF);
    check("b2b cc", cc, 4'b0000);
    check("b2b prev held", held_res, 16'h0F0F);

    // Asynchronous reset in the middle of a multiply.
    @(posedge clk); #1;
    op = 4'd8; a = 16'h0003; b = 16'h0007; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", out_valid, 0);
    check("async rst in_ready", in_ready, 1);
    check("async rst result", result, 16'h0000);
    check("async rst cc", cc, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) stale = 1'b1;
      @(posedge clk); #1;
    end
    check("no stale out_valid", stale, 0);
    do_op("add after rst", 4'd0, 16'd2, 16'd3, 16'h0005, 4'b0000, 1, 0);
    do_op("mul after rst", 4'd8, 16'h0003, 16'h0007, 16'h0015, 4'b0000, 17, 1);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; legal range 8..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 op  input  4  operation code, sampled on acceptance.
REQ-005 a, b  input  WIDTH  operands, sampled on acceptance.
REQ-006 in_valid / in_ready  input / output  1 each  request handshake; accepted when both are high at a rising edge.
REQ-007 result  output  WIDTH  registered result.
REQ-008 cc  output  4  registered flags {N,Z,C,V}, where cc[3]=N and cc[0]=V.
REQ-009 out_valid / out_ready  output / input  1 each  response handshake; consumed when both are high at a rising edge.

Function
REQ-010 The block SHALL implement these op codes:
- 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr (logical), 7 asr: single-cycle ops.
- 8 mul: low WIDTH bits of unsigned a*b.
- 9 divu: quotient.
- 10 remu: remainder.
- 11..15: illegal.
REQ-011 The FSM SHALL have states IDLE, MUL, DIV and HOLD.
- IDLE->HOLD on acceptance of a single-cycle or illegal op.
- IDLE->MUL on op 8; IDLE->DIV on ops 9/10.
- MUL/DIV->HOLD after exactly WIDTH iteration cycles.
- HOLD->IDLE on consumption; HOLD->HOLD (new op) or HOLD->MUL/DIV on consumption with simultaneous acceptance.
REQ-012 in_ready SHALL equal (state==IDLE) || (state==HOLD && out_ready), combinationally.
REQ-013 out_valid SHALL be high exactly in HOLD.
- Single-cycle op: out_valid rises 1 cycle after acceptance.
- mul/div: out_valid rises WIDTH+1 cycles after acceptance.
REQ-014 While out_valid is high and out_ready is low, result and cc SHALL hold stable.
REQ-015 Multiply SHALL be iterative shift-add, one bit per cycle; divide SHALL be restoring, one quotient bit per cycle.
REQ-016 Shift amount SHALL be the full unsigned b.
- b>=WIDTH: shl/shr give 0; asr gives WIDTH copies of a[WIDTH-1].
REQ-017 N SHALL equal result[WIDTH-1], and Z SHALL equal (result==0), for every op.
REQ-018 For add: C = carry out of a+b; V = signed overflow.
REQ-019 For sub: C = carry out of a+~b+1 (C=1 means no borrow); V = signed overflow.
REQ-020 C and V SHALL be 0 for ops 2..8, and for legal divu/remu except as in REQ-021.
REQ-021 Divide by zero (b==0) SHALL give:
- divu: result all-ones.
- remu: result a.
- V=1, C=0.
- Latency still WIDTH+1.
REQ-022 Illegal ops SHALL return result 0 with flags N=0, Z=1, C=0, V=1, at latency 1.
REQ-023 Operand inputs SHALL be ignored when not accepted; no combinational path SHALL exist from a, b or op to any output.

Reset
REQ-024 While rst_n is low, the block SHALL force state=IDLE, result=0, cc=4'b0000, out_valid=0 and iteration counter=0; in_ready SHALL be 1.
REQ-025 Reset asserted mid-MUL/DIV SHALL abort the operation with no output; the first acceptance after deassertion SHALL behave as from a fresh IDLE.

Configuration
REQ-026 Macro ALU_MC_DIV_EN, when defined, SHALL compile in the divider and give ops 9/10 the behaviour in REQ-010/015/021.
REQ-027 When ALU_MC_DIV_EN is undefined, there SHALL be no divider logic and no DIV state; ops 9/10 SHALL be treated as illegal per REQ-022.

Verification (WIDTH=16)
REQ-028 add a=0x7FFF, b=0x0001 -> result 0x8000, cc=1001, out_valid 1 cycle after accept.
REQ-029 sub a=0x0005, b=0x0005 -> 0x0000, cc=0110; then asr a=0x8000, b=20 -> 0xFFFF, cc=1000.
REQ-030 mul a=0x0100, b=0x0100 -> 0x0000, cc=0100, out_valid exactly 17 cycles after accept, in_ready low throughout.
REQ-031 With ALU_MC_DIV_EN: divu 100/7 -> 0x000E; remu 100/7 -> 0x0002; divu 5/0 -> 0xFFFF, cc=1001. Without the macro: divu 100/7 -> 0x0000, cc=0101, latency 1.
REQ-032 Hold out_ready low 3 cycles after an xor result: result and cc stable, in_ready low. Raise out_ready with in_valid high (or 0x00F0|0x000F): back-to-back acceptance, next result 0x00FF one cycle later.
REQ-033 Assert rst_n low at cycle 5 of a mul: outputs reset immediately (asynchronously); after release, an add 2+3 returns 0x0005 with no stale out_valid.
